coremacfilter_crcseq: RTL

//  Receive-side frame sequencer for the 802.3 CRC engine (cini/cval/chld/xcen control).

---
 rtl/coremacfilter_crcseq_if.sv | 20 ++
 rtl/coremacfilter_crcseq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/coremacfilter_crcseq_if.sv
// Receive byte-stream bundle between the MAC front end and the CRC sequencer.
// Signals: rdat/rval/rsof/reof/rabt from master, rrdy back from slave.
interface coremacfilter_crcseq_if;
    logic [7:0] rdat;
    logic       rval;
    logic       rsof;
    logic       reof;
    logic       rabt;
    logic       rrdy;

    modport master (
        output rdat, rval, rsof, reof, rabt,
        input  rrdy
    );

    modport slave (
        input  rdat, rval, rsof, reof, rabt,
        output rrdy
    );
endinterface

// File: rtl/coremacfilter_crcseq.sv
// Receive-side frame sequencer for the 802.3 CRC engine.
// Ports: cclk, crstn (sync, active-low), rx (byte stream, slave),
//   engine controls cdat/cval/cini/chld/xcen, engine status cerr,
//   per-frame status fdone/fgood/fcrcerr/fabort/fshort/flong/flen.
// Optional: CRCSEQ_LENCHK_EN builds MINLEN/MAXLEN length checks;
//   without it fshort/flong are constant 0.
module coremacfilter_crcseq #(
    parameter int unsigned LENW   = 16
`ifdef CRCSEQ_LENCHK_EN
    ,
    parameter int unsigned MINLEN = 64,
    parameter int unsigned MAXLEN = 1518
`endif
) (
    input  logic                 cclk,
    input  logic                 crstn,
    coremacfilter_crcseq_if.slave rx,
    output logic [7:0]           cdat,
    output logic                 cval,
    output logic                 cini,
    output logic                 chld,
    output logic                 xcen,
    input  logic                 cerr,
    output logic                 fdone,
    output logic                 fgood,
    output logic                 fcrcerr,
    output logic                 fabort,
    output logic                 fshort,
    output logic                 flong,
    output logic [LENW-1:0]      flen
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_CHECK
    } state_e;

    localparam logic [LENW-1:0] CNT_MAX = '1;

    state_e          state_q, state_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic [LENW-1:0] flen_q, flen_d;
    logic            fdone_q, fdone_d;
    logic            fgood_q, fgood_d;
    logic            fcrcerr_q, fcrcerr_d;
    logic            fabort_q, fabort_d;
    logic            fshort_q, fshort_d;
    logic            flong_q, flong_d;

    logic            feed;
    logic            preset;
    logic            hold;
    logic            len_short;
    logic            len_long;

`ifdef CRCSEQ_LENCHK_EN
    assign len_short = (cnt_q < LENW'(MINLEN));
    assign len_long  = (cnt_q > LENW'(MAXLEN));
`else
    assign len_short = 1'b0;
    assign len_long  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flen_d    = flen_q;
        fdone_d   = 1'b0;
        fgood_d   = fgood_q;
        fcrcerr_d = fcrcerr_q;
        fabort_d  = fabort_q;
        fshort_d  = fshort_q;
        flong_d   = flong_q;
        feed      = 1'b0;
        preset    = 1'b0;
        hold      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                preset = 1'b1;
                // Bytes without rsof and stray aborts are dropped here.
                if (rx.rval && rx.rsof) begin
                    preset  = 1'b0;
                    feed    = 1'b1;
                    cnt_d   = LENW'(1);
                    state_d = rx.reof ? S_CHECK : S_FRAME;
                end
            end
            S_FRAME: begin
                // A new rsof inside a frame kills the frame in flight.
                if (rx.rabt || (rx.rval && rx.rsof)) begin
                    state_d   = S_IDLE;
                    fdone_d   = 1'b1;
                    fabort_d  = 1'b1;
                    fcrcerr_d = 1'b0;
                    fshort_d  = 1'b0;
                    flong_d   = 1'b0;
                    fgood_d   = 1'b0;
                    flen_d    = cnt_q;
                end else if (rx.rval) begin
                    feed = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + LENW'(1);
                    end
                    if (rx.reof) begin
                        state_d = S_CHECK;
                    end
                end else begin
                    hold = 1'b1;
                end
            end
            S_CHECK: begin
                // Engine has registered the last FCS byte; cerr is final.
                hold      = 1'b1;
                state_d   = S_IDLE;
                fdone_d   = 1'b1;
                fabort_d  = 1'b0;
                fcrcerr_d = cerr;
                fshort_d  = len_short;
                flong_d   = len_long;
                fgood_d   = !cerr && !len_short && !len_long;
                flen_d    = cnt_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk) begin
        if (!crstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            flen_q    <= '0;
            fdone_q   <= 1'b0;
            fgood_q   <= 1'b0;
            fcrcerr_q <= 1'b0;
            fabort_q  <= 1'b0;
            fshort_q  <= 1'b0;
            flong_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flen_q    <= flen_d;
            fdone_q   <= fdone_d;
            fgood_q   <= fgood_d;
            fcrcerr_q <= fcrcerr_d;
            fabort_q  <= fabort_d;
            fshort_q  <= fshort_d;
            flong_q   <= flong_d;
        end
    end

    // Engine controls are combinational for zero-latency feed; reset
    // overrides them so the engine presets while crstn is low.
    assign rx.rrdy = (state_q != S_CHECK);
    assign cval    = crstn && feed;
    assign cdat    = cval ? rx.rdat : 8'h00;
    assign cini    = !crstn || preset;
    assign chld    = crstn && hold;
    assign xcen    = 1'b1;

    assign fdone   = fdone_q;
    assign fgood   = fgood_q;
    assign fcrcerr = fcrcerr_q;
    assign fabort  = fabort_q;
    assign fshort  = fshort_q;
    assign flong   = flong_q;
    assign flen    = flen_q;

endmodule
